// File: rtl/seven_segment_driver.sv
// ============================================================================
//  Module      : seven_segment_driver
//  Description : Registered hex-to-seven-segment decoder with lamp-test,
//                blanking, load enable and selectable output polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_driver #(
    parameter int ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank,
    input  logic       lamp_test,
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out
);

    localparam logic [6:0] C_ALL_OFF  = 7'h00;
    localparam logic [6:0] C_ALL_ON   = 7'h7F;
    // XOR mask applied at the register so every loaded value carries the polarity
    localparam logic [6:0] C_POL_MASK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [6:0] w_decoded;
    logic [6:0] r_seg;

    // Segment order {a,b,c,d,e,f,g}, active-high sense
    always_comb begin
        w_decoded = C_ALL_OFF;
        case (hex_in)
            4'h0: w_decoded = 7'h7E;
            4'h1: w_decoded = 7'h30;
            4'h2: w_decoded = 7'h6D;
            4'h3: w_decoded = 7'h79;
            4'h4: w_decoded = 7'h33;
            4'h5: w_decoded = 7'h5B;
            4'h6: w_decoded = 7'h5F;
            4'h7: w_decoded = 7'h70;
            4'h8: w_decoded = 7'h7F;
            4'h9: w_decoded = 7'h73;
            4'hA: w_decoded = 7'h77;
            4'hB: w_decoded = 7'h1F;
            4'hC: w_decoded = 7'h4E;
            4'hD: w_decoded = 7'h3D;
            4'hE: w_decoded = 7'h4F;
            4'hF: w_decoded = 7'h47;
            default: w_decoded = C_ALL_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= C_ALL_OFF ^ C_POL_MASK;
        end else if (lamp_test) begin
            r_seg <= C_ALL_ON ^ C_POL_MASK;
        end else if (blank) begin
            r_seg <= C_ALL_OFF ^ C_POL_MASK;
        end else if (en) begin
            r_seg <= w_decoded ^ C_POL_MASK;
        end
    end

    assign seg_out = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_driver.sv
// ============================================================================
//  Module      : tb_seven_segment_driver
//  Description : Self-checking bench driving active-high and active-low
//                instances from shared directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [3:0] hex_in = 4'h0;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;

    int checks = 0;
    int failures = 0;

    // Glyph table written out from the segment drawings (lit segments = 1)
    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model: which segments are lit, independent of drive polarity
    logic [6:0] lit = 7'h00;
    logic       lit_valid = 1'b0;

    seven_segment_driver #(.ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .blank(blank),
        .lamp_test(lamp_test), .hex_in(hex_in), .seg_out(seg_hi)
    );

    seven_segment_driver #(.ACTIVE_LOW(1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .blank(blank),
        .lamp_test(lamp_test), .hex_in(hex_in), .seg_out(seg_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got 7'h%02h, required 7'h%02h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            lit       <= 7'h00;
            lit_valid <= 1'b1;
        end else if (lit_valid) begin
            if (lamp_test)  lit <= 7'h7F;
            else if (blank) lit <= 7'h00;
            else if (en)    lit <= glyph[hex_in];
        end
    end

    always @(negedge clk) begin
        if (lit_valid) begin
            check("model_hi", seg_hi, lit);
            check("model_lo", seg_lo, ~lit);
        end
    end

    // Apply inputs at a falling edge; returns after the next rising edge has
    // registered them, so outputs then reflect exactly these inputs.
    task automatic cyc(input logic r, input logic e, input logic b,
                       input logic lt, input logic [3:0] h);
        rst = r; en = e; blank = b; lamp_test = lt; hex_in = h;
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] sweep_lit [16];
        sweep_lit = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                      7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

        @(negedge clk);

        // Reset dominates lamp_test and en
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h8);
            check("reset_hi", seg_hi, 7'h00);
            check("reset_lo", seg_lo, 7'h7F);
        end

        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'(i));
            check("sweep_hi", seg_hi, sweep_lit[i]);
        end

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h5);
        check("hold_load", seg_hi, 7'h5B);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
            check("hold", seg_hi, 7'h5B);
        end

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h3);
        check("ovr_load", seg_hi, 7'h79);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h3);
        check("ovr_blank", seg_hi, 7'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
        check("ovr_lamp_over_blank", seg_hi, 7'h7F);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
        check("ovr_stick", seg_hi, 7'h7F);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h3);
        check("ovr_reload", seg_hi, 7'h79);

        // Blank without en still forces off, and stays off after release
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h3);
        check("blank_no_en", seg_hi, 7'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
        check("blank_stick", seg_hi, 7'h00);

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("lo_zero", seg_lo, 7'h01);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        check("lo_f", seg_lo, 7'h38);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
        check("lo_lamp", seg_lo, 7'h00);

        for (int i = 0; i < 16; i++) begin
            cyc(i == 7, 1'b1, 1'b0, 1'b0, 4'(i));
            if (i == 7) check("mid_reset", seg_hi, 7'h00);
            else        check("mid_stream", seg_hi, sweep_lit[i]);
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
